matmul_operand_loader: RTL and testbench
========================================

Name: matmul_operand_loader

Overview:
- Initiator-side front end for the 4x32 by 32x4 int8 matrix multiplier.
- Accepts a byte stream (valid/ready) and unpacks it into the multiplier's A and B operand arrays.
- Issues the start request, then waits for the multiplier's done before taking the next frame.
- Reports frame completion, framing errors and timeout.

Parameters:
ROWS, 4, rows of A and rows of the result
DEPTH, 32, inner dimension (columns of A, rows of B)
COLS, 4, columns of B
DW, 8, operand element width
TIMEOUT, 4096, max cycles to wait for mm_done after start

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
s_valid  in  1  input byte valid
s_ready  out  1  loader can accept a byte
s_data  in  DW  operand byte
s_last  in  1  marks final byte of a frame
a_out  out  ROWS x DEPTH x DW  operand A array, a_out[r][k]
b_out  out  DEPTH x COLS x DW  operand B array, b_out[k][c]
mm_start  out  1  start request to multiplier
mm_done  in  1  multiplier done (may be level/sticky)
busy  out  1  high in any state other than IDLE
frame_ok  out  1  1-cycle pulse on mm_done rising edge for this frame
err_len  out  1  1-cycle pulse on framing error
err_timeout  out  1  1-cycle pulse on wait timeout

Behaviour:
- Reset (async, any state): state=IDLE; all a_out/b_out elements 0; byte counter 0; timeout counter 0; mm_start=0; frame_ok=err_len=err_timeout=0; busy=0; s_ready=0 during reset, 1 the cycle after.
- Frame: NA=ROWS*DEPTH (128) bytes of A row-major, then NB=DEPTH*COLS (128) bytes of B row-major; total 256 bytes.
- Byte n<NA writes a_out[n/DEPTH][n%DEPTH]. Byte n>=NA, with m=n-NA, writes b_out[m/COLS][m%COLS].
- Transfer occurs when s_valid && s_ready. Written element is visible the next cycle.
- States:
  - IDLE: s_ready=1. First transfer writes byte 0 and moves to LOAD.
  - LOAD: s_ready=1; counter increments per transfer.
  - START: s_ready=0; mm_start=1 for exactly one cycle; capture current mm_done as done_prev; go to WAIT.
  - WAIT: s_ready=0; mm_start=0; timeout counter increments per cycle.
- Last byte: transfer of byte 255 with s_last=1 goes to START on the next cycle.
- Early last: s_last=1 on any byte before 255 -> byte is written, err_len pulses, counter clears, return to IDLE, no mm_start.
- Missing last: byte 255 with s_last=0 -> err_len pulses, return to IDLE, no mm_start.
- Completion: mm_done high while done_prev low -> frame_ok pulses, return to IDLE.
  - Edge detection is required because mm_done may stay high from a prior frame.
  - done_prev updates every WAIT cycle.
- Timeout: counter reaches TIMEOUT-1 in WAIT without a completion edge -> err_timeout pulses, return to IDLE.
  - Simultaneous completion edge and timeout: completion wins (frame_ok only).
- Operand stability: a_out/b_out change only on transfers. They are held unchanged through START and WAIT and retained after return to IDLE until overwritten.
- Error cases leave partially written operands in place; the next frame overwrites all 256 elements.
- busy=1 in LOAD, START, WAIT.
- Latency: last-byte transfer at cycle t -> mm_start high at t+1 -> earliest frame_ok at t+3 (mm_done edge seen at t+2).
- Counter widths: byte counter clog2(NA+NB) bits; timeout counter clog2(TIMEOUT) bits. No wrap occurs, since every terminal count forces an exit.

Test Plan:
- Full frame: bytes n=0..255 with data=n, s_last on byte 255, s_valid continuous -> a_out[1][3]=35, a_out[3][31]=127, b_out[0][0]=128, b_out[31][3]=255; mm_start 1 cycle at t+1; mm_done driven high 10 cycles later -> frame_ok pulse; busy falls.
- Backpressure/gaps: random s_valid deassertion across 256 bytes -> same array contents as full frame; no byte dropped or duplicated.
- Sticky done: mm_done held high before the frame starts -> no frame_ok until mm_done drops and rises again; if it never re-rises, err_timeout pulses exactly TIMEOUT cycles after entering WAIT.
- Early s_last on byte 100 -> err_len pulse, no mm_start, s_ready=1 next cycle; a full second frame then completes normally.
- Missing s_last on byte 255 -> err_len pulse, state IDLE, no mm_start.
- Reset asserted mid-LOAD (byte 60) and mid-WAIT -> all outputs and arrays 0 immediately; s_ready=1 after release; next frame completes normally.

Source files
------------

// File: rtl/matmul_operand_loader.sv
// matmul_operand_loader: unpacks a byte stream into the A/B operands of the int8 matrix multiplier, starts it and waits for done
// Ports:
//   clk, rst                        clock (rising edge), asynchronous active-high reset
//   s_valid, s_ready, s_data, s_last  byte stream in: A row-major, then B row-major, s_last on the final byte
//   a_out[r][k], b_out[k][c]        operand arrays; they change only on stream transfers
//   mm_start, mm_done               start pulse to the multiplier, its done (may stay high between frames)
//   busy                            high whenever the loader is not idle
//   frame_ok, err_len, err_timeout  one-cycle event pulses
module matmul_operand_loader #(
    parameter int ROWS    = 4,
    parameter int DEPTH   = 32,
    parameter int COLS    = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [DW-1:0]                        s_data,
    input  logic                                 s_last,
    output logic [ROWS-1:0][DEPTH-1:0][DW-1:0]   a_out,
    output logic [DEPTH-1:0][COLS-1:0][DW-1:0]   b_out,
    output logic                                 mm_start,
    input  logic                                 mm_done,
    output logic                                 busy,
    output logic                                 frame_ok,
    output logic                                 err_len,
    output logic                                 err_timeout
);
    localparam int NA = ROWS * DEPTH;
    localparam int NT = NA + DEPTH * COLS;
    localparam int CW = $clog2(NT);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tcnt;
    logic r_done_prev, r_ready_en, r_frame_ok, r_err_len, r_err_timeout;
    logic w_xfer, w_last_byte, w_edge, w_tmo, w_frame_ok, w_err_len, w_err_timeout;
    logic [ROWS-1:0][DEPTH-1:0][DW-1:0] r_a;
    logic [DEPTH-1:0][COLS-1:0][DW-1:0] r_b;
    // r_ready_en keeps s_ready low while reset is held and for no longer than the first clock after it
    assign s_ready     = r_ready_en && (r_state == IDLE || r_state == LOAD);
    assign mm_start    = r_state == START;
    assign busy        = r_state != IDLE;
    assign frame_ok    = r_frame_ok;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_timeout;
    assign a_out       = r_a;
    assign b_out       = r_b;
    always_comb begin
        w_next        = r_state;
        w_frame_ok    = 1'b0;
        w_err_len     = 1'b0;
        w_err_timeout = 1'b0;
        w_xfer        = s_valid && s_ready;
        w_last_byte   = r_cnt == CW'(NT - 1);
        // mm_done may still be high from the previous frame, so only a rising edge counts
        w_edge        = mm_done && !r_done_prev;
        w_tmo         = r_tcnt == TW'(TIMEOUT - 1);
        case (r_state)
            IDLE, LOAD: if (w_xfer) begin
                w_next    = (s_last && w_last_byte) ? START : (s_last || w_last_byte) ? IDLE : LOAD;
                w_err_len = s_last != w_last_byte;
            end
            START: w_next = WAIT;
            WAIT: begin
                // a completion edge in the timeout cycle wins over the timeout
                w_frame_ok    = w_edge;
                w_err_timeout = !w_edge && w_tmo;
                w_next        = (w_edge || w_tmo) ? IDLE : WAIT;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_tcnt        <= '0;
            r_done_prev   <= 1'b0;
            r_ready_en    <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_ready_en    <= 1'b1;
            r_frame_ok    <= w_frame_ok;
            r_err_len     <= w_err_len;
            r_err_timeout <= w_err_timeout;
            if (w_xfer)
                r_cnt <= (w_next == LOAD) ? r_cnt + 1'b1 : '0;
            r_tcnt <= (r_state == WAIT && w_next == WAIT) ? r_tcnt + 1'b1 : '0;
            if (r_state == START || r_state == WAIT)
                r_done_prev <= mm_done;
        end
    end
    // byte n lands in element n of A (row-major), then element n-NA of B (row-major)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_xfer) begin
            for (int r = 0; r < ROWS; r++)
                for (int k = 0; k < DEPTH; k++)
                    if (r_cnt == CW'(r * DEPTH + k))
                        r_a[r][k] <= s_data;
            for (int k = 0; k < DEPTH; k++)
                for (int c = 0; c < COLS; c++)
                    if (r_cnt == CW'(NA + k * COLS + c))
                        r_b[k][c] <= s_data;
        end
    end
endmodule

// File: tb/tb_matmul_operand_loader.sv
// tb_matmul_operand_loader: directed and randomized frames against a byte-indexed reference of the operand arrays
module tb_matmul_operand_loader;
    localparam int ROWS = 4, DEPTH = 32, COLS = 4, DW = 8, TIMEOUT = 4096;
    localparam int NA = ROWS * DEPTH, NT = NA + DEPTH * COLS;
    logic clk = 1'b0, rst = 1'b1;
    logic s_valid = 1'b0, s_last = 1'b0, mm_done = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic s_ready, mm_start, busy, frame_ok, err_len, err_timeout;
    logic [ROWS-1:0][DEPTH-1:0][DW-1:0] a_out;
    logic [DEPTH-1:0][COLS-1:0][DW-1:0] b_out;
    logic [7:0] ma [ROWS][DEPTH];
    logic [7:0] mb [DEPTH][COLS];
    int checks = 0, errors = 0;
    int n_start = 0, n_ok = 0, n_len = 0, n_tmo = 0;
    int s0, o0, l0, t0;

    matmul_operand_loader #(.ROWS(ROWS), .DEPTH(DEPTH), .COLS(COLS), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .a_out(a_out), .b_out(b_out), .mm_start(mm_start), .mm_done(mm_done), .busy(busy),
        .frame_ok(frame_ok), .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mm_start) n_start++;
        if (frame_ok) n_ok++;
        if (err_len) n_len++;
        if (err_timeout) n_tmo++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_arrays(input string tag);
        string where = "none";
        logic [7:0] got = '0, want = '0;
        bit ok = 1'b1;
        for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < DEPTH; k++)
                if (ok && a_out[r][k] !== ma[r][k]) begin
                    ok = 1'b0; where = $sformatf("a[%0d][%0d]", r, k); got = a_out[r][k]; want = ma[r][k];
                end
        for (int k = 0; k < DEPTH; k++)
            for (int c = 0; c < COLS; c++)
                if (ok && b_out[k][c] !== mb[k][c]) begin
                    ok = 1'b0; where = $sformatf("b[%0d][%0d]", k, c); got = b_out[k][c]; want = mb[k][c];
                end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL %s: %s observed %0h expected %0h", tag, where, got, want);
        end
    endtask

    task automatic model_clear();
        foreach (ma[r, k]) ma[r][k] = '0;
        foreach (mb[k, c]) mb[k][c] = '0;
    endtask

    // frame byte n is element n of A in row-major order, then element n-NA of B in row-major order
    task automatic model_write(input int n, input logic [7:0] d);
        if (n < NA) ma[n / DEPTH][n % DEPTH] = d;
        else mb[(n - NA) / COLS][(n - NA) % COLS] = d;
    endtask

    task automatic snap();
        #1;
        s0 = n_start; o0 = n_ok; l0 = n_len; t0 = n_tmo;
    endtask

    // called at a negedge; returns at the negedge after the transfer edge
    task automatic push(input int n, input logic [7:0] d, input bit last, input bit gaps);
        int g = 0;
        if (gaps)
            while ($urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        while (!s_ready && g < 20) begin
            s_valid = 1'b0;
            @(negedge clk);
            g++;
        end
        if (!s_ready) chk("push_ready", s_ready, 1'b1);
        s_valid = 1'b1; s_data = d; s_last = last;
        model_write(n, d);
        @(negedge clk);
    endtask

    task automatic send_frame(input int nbytes, input int last_at, input bit rnd);
        for (int n = 0; n < nbytes; n++)
            push(n, rnd ? 8'($urandom) : 8'(n), n == last_at, rnd);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    // entered at the negedge right after the last-byte transfer
    task automatic complete(input string tag, input int delay);
        chk({tag, "_start"}, mm_start, 1'b1);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_ready0"}, s_ready, 1'b0);
        @(negedge clk);
        chk({tag, "_start_1cyc"}, mm_start, 1'b0);
        repeat (delay - 1) @(negedge clk);
        mm_done = 1'b1;
        @(negedge clk);
        chk({tag, "_frame_ok"}, frame_ok, 1'b1);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_ready1"}, s_ready, 1'b1);
        @(negedge clk);
        chk({tag, "_ok_pulse"}, frame_ok, 1'b0);
        mm_done = 1'b0;
    endtask

    task automatic reset_now(input string tag);
        rst = 1'b1;
        s_valid = 1'b0; s_last = 1'b0; mm_done = 1'b0;
        model_clear();
        #1;
        chk({tag, "_ready"}, s_ready, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_start"}, mm_start, 1'b0);
        chk({tag, "_pulses"}, {frame_ok, err_len, err_timeout}, 3'b000);
        chk_arrays({tag, "_arrays"});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk({tag, "_ready_after"}, s_ready, 1'b1);
    endtask

    initial begin
        int c;
        model_clear();
        repeat (2) @(negedge clk);
        reset_now("reset");

        // full frame, data = byte index, continuous valid
        snap();
        send_frame(NT, NT - 1, 1'b0);
        chk("full_a13", a_out[1][3], 35);
        chk("full_a331", a_out[3][31], 127);
        chk("full_b00", b_out[0][0], 128);
        chk("full_b313", b_out[31][3], 255);
        chk_arrays("full_arrays");
        complete("full", 10);
        #1;
        chk("full_nstart", n_start - s0, 1);
        chk("full_nok", n_ok - o0, 1);

        // random data with random valid gaps
        snap();
        send_frame(NT, NT - 1, 1'b1);
        chk_arrays("gaps_arrays");
        complete("gaps", $urandom_range(1, 30));
        chk_arrays("gaps_held");
        #1;
        chk("gaps_nok", n_ok - o0, 1);

        // sticky done: no completion until done falls and rises again
        mm_done = 1'b1;
        repeat (3) @(negedge clk);
        snap();
        send_frame(NT, NT - 1, 1'b1);
        chk("sticky_start", mm_start, 1'b1);
        repeat (20) @(negedge clk);
        chk("sticky_busy", busy, 1'b1);
        mm_done = 1'b0;
        repeat (2) @(negedge clk);
        mm_done = 1'b1;
        @(negedge clk);
        chk("sticky_ok", frame_ok, 1'b1);
        #1;
        chk("sticky_nok", n_ok - o0, 1);
        chk("sticky_ntmo", n_tmo - t0, 0);
        chk_arrays("sticky_arrays");

        // sticky done that never re-rises: timeout
        @(negedge clk);
        snap();
        send_frame(NT, NT - 1, 1'b1);
        chk("tmo_start", mm_start, 1'b1);
        @(negedge clk);
        c = 0;
        while (!err_timeout && c < TIMEOUT + 10) begin
            @(negedge clk);
            c++;
        end
        chk("tmo_cycles", c, TIMEOUT);
        chk("tmo_idle", busy, 1'b0);
        #1;
        chk("tmo_nok", n_ok - o0, 0);
        chk("tmo_ntmo", n_tmo - t0, 1);
        mm_done = 1'b0;
        @(negedge clk);
        chk("tmo_pulse", err_timeout, 1'b0);

        // early s_last on byte 100
        snap();
        send_frame(101, 100, 1'b1);
        chk("early_err", err_len, 1'b1);
        chk("early_ready", s_ready, 1'b1);
        chk("early_idle", busy, 1'b0);
        chk_arrays("early_arrays");
        @(negedge clk);
        chk("early_pulse", err_len, 1'b0);
        #1;
        chk("early_nstart", n_start - s0, 0);
        send_frame(NT, NT - 1, 1'b1);
        chk_arrays("early_next_arrays");
        complete("early_next", 5);

        // missing s_last on byte 255
        snap();
        send_frame(NT, -1, 1'b1);
        chk("miss_err", err_len, 1'b1);
        chk("miss_idle", busy, 1'b0);
        chk("miss_ready", s_ready, 1'b1);
        chk_arrays("miss_arrays");
        @(negedge clk);
        #1;
        chk("miss_nstart", n_start - s0, 0);
        chk("miss_nlen", n_len - l0, 1);

        // reset mid-LOAD at byte 60
        send_frame(60, -1, 1'b1);
        chk("load_busy", busy, 1'b1);
        reset_now("rst_load");
        send_frame(NT, NT - 1, 1'b1);
        complete("after_load_rst", 3);
        chk_arrays("after_load_rst_arrays");

        // reset mid-WAIT
        send_frame(NT, NT - 1, 1'b1);
        repeat (6) @(negedge clk);
        chk("wait_busy", busy, 1'b1);
        reset_now("rst_wait");
        snap();
        send_frame(NT, NT - 1, 1'b1);
        complete("after_wait_rst", 1);
        chk_arrays("after_wait_rst_arrays");
        #1;
        chk("final_nstart", n_start - s0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end
endmodule
